keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_CYCLES, default 16: clocks each column stays driven before its rows are evaluated; legal range 4..65535.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000: consecutive stable evaluations required for press and for release; legal range 2..65535.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-006 col_n  output  4  column drive, active-low, at most one bit low at any time.
REQ-007 key_pressed  output  1  level, high while a debounced key is held.
REQ-008 key_code  output  4  code of the accepted key.
REQ-009 is_sign_key  output  1  high when key_code is 14 or 15.
REQ-010 key_neg  output  1  high when key_code is 14 ('*' = negative sign).
REQ-011 key_valid  output  1  one-cycle pulse on press acceptance.

Function
REQ-012 row_n SHALL pass a 2-flop synchronizer (reset value 4'b1111); all row decisions use the synchronized value.
REQ-013 Key map (row r, column c) -> key_code: r0: 1,2,3,10; r1: 4,5,6,11; r2: 7,8,9,12; r3: 14('*'),0,15('#'),13.
REQ-014 States: SCAN, DEB_PRESS, PRESSED, DEB_RELEASE.
REQ-015 SCAN: the cycle counter runs 0..SCAN_CYCLES-1 with the current column driven low; rows are evaluated only when the counter equals SCAN_CYCLES-1.
REQ-016 SCAN evaluation, exactly one synchronized row low: latch row and column, freeze col_n, clear the debounce counter, go to DEB_PRESS.
REQ-017 SCAN evaluation, zero rows or two or more rows low: advance the column 0->1->2->3->0 (wrap), clear the cycle counter, stay in SCAN.
REQ-018 DEB_PRESS: each cycle where the synchronized rows equal the latched one-low pattern increments the counter; any other pattern returns to SCAN at the next column with no output change.
REQ-019 DEB_PRESS, counter reaching DEBOUNCE_CYCLES: go to PRESSED; in the same edge, load key_code, is_sign_key and key_neg and set key_pressed=1 and key_valid=1.
REQ-020 key_code, is_sign_key and key_neg SHALL be valid in the first cycle key_pressed is high and stable until the next accepted press.
REQ-021 key_valid SHALL be high for exactly one cycle per accepted press.
REQ-022 PRESSED: col_n stays frozen; the latched row going high (any other row pattern) clears the counter and enters DEB_RELEASE; key_pressed stays 1.
REQ-023 DEB_RELEASE: each cycle with all synchronized rows high increments the counter; any row low returns to PRESSED with no new key_valid.
REQ-024 DEB_RELEASE, counter reaching DEBOUNCE_CYCLES: key_pressed=0, return to SCAN at the next column, cycle counter cleared.
REQ-025 A second key pressed while one is held SHALL NOT produce a new press; only the latched key is tracked.
REQ-026 Minimum latency from a stable press (synchronized) to key_pressed rising SHALL be DEBOUNCE_CYCLES+1 clocks after the column evaluation.

Reset
REQ-027 While rst=0: state SCAN, column 0 active (col_n=4'b1110), both counters 0, synchronizer 4'b1111, key_pressed=0, key_valid=0, key_code=0, is_sign_key=0, key_neg=0.
REQ-028 Reset asserted mid-debounce or mid-press SHALL drop key_pressed immediately, with no key_valid on release of reset until a full new debounce completes.

Verification (SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-029 Hold row 1 low while col_n=4'b1011 -> after debounce, key_pressed=1 and key_code=6, is_sign_key=0, one key_valid pulse; release row -> key_pressed=0 after 8 clean cycles.
REQ-030 Press row 3 / column 0 -> key_code=14, is_sign_key=1, key_neg=1; press row 3 / column 2 -> key_code=15, is_sign_key=1, key_neg=0.
REQ-031 Bounce: row toggles low/high every 3 cycles for 30 cycles then is held low -> exactly one key_valid, and key_pressed never pulses during the bounce.
REQ-032 Rows 0 and 2 low together in one column -> no transition out of SCAN, col_n keeps cycling 1110->1101->1011->0111->1110.
REQ-033 Release glitch: in PRESSED, row high for 3 cycles then low again -> key_pressed stays 1, no second key_valid.
REQ-034 rst=0 asserted in PRESSED -> outputs at reset values (REQ-027) asynchronously; after rst=1 with key still held, a new debounce yields one key_valid.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the columns, debounces a single-row press and
// its release, and reports the decoded key with sign-key flags.
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_pressed,
    output logic [3:0] key_code,
    output logic       is_sign_key,
    output logic       key_neg,
    output logic       key_valid
);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

    localparam logic [15:0] SCAN_LAST = 16'(SCAN_CYCLES - 1);
    localparam logic [15:0] DEB_LAST  = 16'(DEBOUNCE_CYCLES - 1);

    state_t      state, state_nx;
    logic [3:0]  row_s1, row_s2;
    logic [15:0] cyc_cnt, cyc_cnt_nx;
    logic [15:0] deb_cnt, deb_cnt_nx;
    logic [1:0]  col_idx, col_idx_nx;
    logic [3:0]  row_lat, row_lat_nx;
    logic        key_pressed_nx, key_valid_nx, is_sign_key_nx, key_neg_nx;
    logic [3:0]  key_code_nx;
    logic [3:0]  code_sel;

    function automatic logic one_low(input logic [3:0] r);
        return (r == 4'b1110) || (r == 4'b1101) || (r == 4'b1011) || (r == 4'b0111);
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] r);
        case (r)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return 4'd1;   4'h1: return 4'd2;  4'h2: return 4'd3;  4'h3: return 4'd10;
            4'h4: return 4'd4;   4'h5: return 4'd5;  4'h6: return 4'd6;  4'h7: return 4'd11;
            4'h8: return 4'd7;   4'h9: return 4'd8;  4'hA: return 4'd9;  4'hB: return 4'd12;
            4'hC: return 4'd14;  4'hD: return 4'd0;  4'hE: return 4'd15; default: return 4'd13;
        endcase
    endfunction

    // Column index stays put outside SCAN, which is what freezes the drive.
    assign col_n    = ~(4'b0001 << col_idx);
    assign code_sel = key_map(row_index(row_lat), col_idx);

    always_comb begin
        state_nx       = state;
        cyc_cnt_nx     = cyc_cnt;
        deb_cnt_nx     = deb_cnt;
        col_idx_nx     = col_idx;
        row_lat_nx     = row_lat;
        key_pressed_nx = key_pressed;
        key_code_nx    = key_code;
        is_sign_key_nx = is_sign_key;
        key_neg_nx     = key_neg;
        key_valid_nx   = 1'b0;
        case (state)
            SCAN: begin
                if (cyc_cnt == SCAN_LAST) begin
                    if (one_low(row_s2)) begin
                        row_lat_nx = row_s2;
                        deb_cnt_nx = '0;
                        state_nx   = DEB_PRESS;
                    end else begin
                        col_idx_nx = col_idx + 2'd1;
                        cyc_cnt_nx = '0;
                    end
                end else begin
                    cyc_cnt_nx = cyc_cnt + 16'd1;
                end
            end
            DEB_PRESS: begin
                if (row_s2 == row_lat) begin
                    if (deb_cnt == DEB_LAST) begin
                        state_nx       = PRESSED;
                        key_code_nx    = code_sel;
                        is_sign_key_nx = (code_sel >= 4'd14);
                        key_neg_nx     = (code_sel == 4'd14);
                        key_pressed_nx = 1'b1;
                        key_valid_nx   = 1'b1;
                    end else begin
                        deb_cnt_nx = deb_cnt + 16'd1;
                    end
                end else begin
                    state_nx   = SCAN;
                    col_idx_nx = col_idx + 2'd1;
                    cyc_cnt_nx = '0;
                end
            end
            PRESSED: begin
                if (row_s2 != row_lat) begin
                    deb_cnt_nx = '0;
                    state_nx   = DEB_RELEASE;
                end
            end
            DEB_RELEASE: begin
                if (row_s2 == 4'b1111) begin
                    if (deb_cnt == DEB_LAST) begin
                        key_pressed_nx = 1'b0;
                        state_nx       = SCAN;
                        col_idx_nx     = col_idx + 2'd1;
                        cyc_cnt_nx     = '0;
                    end else begin
                        deb_cnt_nx = deb_cnt + 16'd1;
                    end
                end else begin
                    state_nx = PRESSED;
                end
            end
            default: state_nx = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SCAN;
            row_s1      <= 4'b1111;
            row_s2      <= 4'b1111;
            cyc_cnt     <= '0;
            deb_cnt     <= '0;
            col_idx     <= 2'd0;
            row_lat     <= 4'b1111;
            key_pressed <= 1'b0;
            key_code    <= 4'd0;
            is_sign_key <= 1'b0;
            key_neg     <= 1'b0;
            key_valid   <= 1'b0;
        end else begin
            state       <= state_nx;
            row_s1      <= row_n;
            row_s2      <= row_s1;
            cyc_cnt     <= cyc_cnt_nx;
            deb_cnt     <= deb_cnt_nx;
            col_idx     <= col_idx_nx;
            row_lat     <= row_lat_nx;
            key_pressed <= key_pressed_nx;
            key_code    <= key_code_nx;
            is_sign_key <= is_sign_key_nx;
            key_neg     <= key_neg_nx;
            key_valid   <= key_valid_nx;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural two-key keypad model.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       key_pressed, is_sign_key, key_neg, key_valid;
    logic [3:0] key_code;

    logic       k1_en = 1'b0, k2_en = 1'b0;
    logic [1:0] k1_r = 2'd0, k1_c = 2'd0, k2_r = 2'd0, k2_c = 2'd0;

    int pass_cnt = 0;
    int total_cnt = 0;
    int vcnt = 0;
    int rise_cnt = 0;
    logic prev_p = 1'b0;

    keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
        .key_pressed(key_pressed), .key_code(key_code), .is_sign_key(is_sign_key),
        .key_neg(key_neg), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    // A held key pulls its row low only while its column is driven.
    always_comb begin
        row_n = 4'b1111;
        if (k1_en && col_n[k1_c] == 1'b0) row_n[k1_r] = 1'b0;
        if (k2_en && col_n[k2_c] == 1'b0) row_n[k2_r] = 1'b0;
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) vcnt++;
        if (key_pressed === 1'b1 && prev_p !== 1'b1) rise_cnt++;
        prev_p = key_pressed;
    end

    task automatic wait_pressed(input logic lvl, input int budget, output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < budget && !ok) begin
            @(negedge clk);
            n++;
            if (key_pressed === lvl) ok = 1'b1;
        end
    endtask

    task automatic release_all(input string tag);
        int n;
        bit ok;
        k1_en = 1'b0;
        k2_en = 1'b0;
        wait_pressed(1'b0, 100, n, ok);
        total_cnt++;
        if (!ok) $display("FAIL %s_release: key_pressed still %b after %0d cycles, required 0", tag, key_pressed, n);
        else pass_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({col_n, key_pressed, key_valid, key_code, is_sign_key, key_neg} !== {4'b1110, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0})
            $display("FAIL reset_outputs: col_n=%b kp=%b kv=%b code=%0d sign=%b neg=%b, required 1110 0 0 0 0 0",
                     col_n, key_pressed, key_valid, key_code, is_sign_key, key_neg);
        else pass_cnt++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_press();
        int n;
        bit ok;
        vcnt = 0;
        k1_r = 2'd1; k1_c = 2'd2; k1_en = 1'b1;
        wait_pressed(1'b1, 200, n, ok);
        total_cnt++;
        if (!ok || n < 11) $display("FAIL basic_press_latency: rose=%b after %0d cycles, required rise after >=11", ok, n);
        else pass_cnt++;
        total_cnt++;
        if ({key_code, is_sign_key, key_neg} !== {4'd6, 1'b0, 1'b0})
            $display("FAIL basic_code: code=%0d sign=%b neg=%b, required 6 0 0", key_code, is_sign_key, key_neg);
        else pass_cnt++;
        repeat (5) @(negedge clk);
        total_cnt++;
        if (vcnt != 1 || col_n !== 4'b1011)
            $display("FAIL basic_valid_freeze: valid pulses=%0d col_n=%b, required 1 1011", vcnt, col_n);
        else pass_cnt++;
        k1_en = 1'b0;
        wait_pressed(1'b0, 100, n, ok);
        total_cnt++;
        if (!ok || n != 11) $display("FAIL basic_release_latency: fell=%b after %0d cycles, required 11", ok, n);
        else pass_cnt++;
        total_cnt++;
        if (col_n !== 4'b0111 || key_code !== 4'd6)
            $display("FAIL basic_after_release: col_n=%b code=%0d, required 0111 6", col_n, key_code);
        else pass_cnt++;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_sign_keys();
        int n;
        bit ok;
        k1_r = 2'd3; k1_c = 2'd0; k1_en = 1'b1;
        wait_pressed(1'b1, 200, n, ok);
        total_cnt++;
        if (!ok || {key_code, is_sign_key, key_neg} !== {4'd14, 1'b1, 1'b1})
            $display("FAIL sign_star: ok=%b code=%0d sign=%b neg=%b, required 14 1 1", ok, key_code, is_sign_key, key_neg);
        else pass_cnt++;
        release_all("sign_star");
        k1_r = 2'd3; k1_c = 2'd2; k1_en = 1'b1;
        wait_pressed(1'b1, 200, n, ok);
        total_cnt++;
        if (!ok || {key_code, is_sign_key, key_neg} !== {4'd15, 1'b1, 1'b0})
            $display("FAIL sign_hash: ok=%b code=%0d sign=%b neg=%b, required 15 1 0", ok, key_code, is_sign_key, key_neg);
        else pass_cnt++;
        release_all("sign_hash");
        total_cnt++;
        if ({key_code, is_sign_key, key_neg} !== {4'd15, 1'b1, 1'b0})
            $display("FAIL code_hold: code=%0d sign=%b neg=%b, required 15 1 0", key_code, is_sign_key, key_neg);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        int n;
        bit ok;
        bit saw = 1'b0;
        vcnt = 0;
        rise_cnt = 0;
        k1_r = 2'd0; k1_c = 2'd1;
        for (int i = 0; i < 30; i++) begin
            k1_en = ((i / 3) % 2 == 0);
            @(negedge clk);
            if (key_pressed !== 1'b0) saw = 1'b1;
        end
        k1_en = 1'b1;
        wait_pressed(1'b1, 200, n, ok);
        repeat (4) @(negedge clk);
        total_cnt++;
        if (!ok || saw || vcnt != 1 || rise_cnt != 1 || key_code !== 4'd2)
            $display("FAIL bounce: ok=%b pulsed_during_bounce=%b valid=%0d rises=%0d code=%0d, required 1 0 1 1 2",
                     ok, saw, vcnt, rise_cnt, key_code);
        else pass_cnt++;
        release_all("bounce");
    endtask

    task automatic test_multi_row();
        logic [3:0] prev;
        int gap = 0;
        int changes = 0;
        vcnt = 0;
        k1_r = 2'd0; k1_c = 2'd1; k1_en = 1'b1;
        k2_r = 2'd2; k2_c = 2'd1; k2_en = 1'b1;
        prev = col_n;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            gap++;
            if (col_n !== prev) begin
                total_cnt++;
                if (col_n !== {prev[2:0], prev[3]} || (changes > 0 && gap != 4))
                    $display("FAIL multi_row_cycle: col_n %b -> %b after %0d cycles, required %b after 4",
                             prev, col_n, gap, {prev[2:0], prev[3]});
                else pass_cnt++;
                changes++;
                gap = 0;
                prev = col_n;
            end
        end
        total_cnt++;
        if (changes < 12 || vcnt != 0 || key_pressed !== 1'b0)
            $display("FAIL multi_row_stay_scan: changes=%0d valid=%0d kp=%b, required >=12 0 0", changes, vcnt, key_pressed);
        else pass_cnt++;
        k1_en = 1'b0;
        k2_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_release_glitch();
        int n;
        bit ok;
        bit dropped = 1'b0;
        k1_r = 2'd2; k1_c = 2'd3; k1_en = 1'b1;
        wait_pressed(1'b1, 200, n, ok);
        total_cnt++;
        if (!ok || key_code !== 4'd12) $display("FAIL glitch_press: ok=%b code=%0d, required 1 12", ok, key_code);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        vcnt = 0;
        k1_en = 1'b0;
        repeat (3) @(negedge clk);
        k1_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (key_pressed !== 1'b1) dropped = 1'b1;
        end
        total_cnt++;
        if (dropped || vcnt != 0)
            $display("FAIL release_glitch: dropped=%b extra_valid=%0d, required 0 0", dropped, vcnt);
        else pass_cnt++;
        release_all("glitch");
    endtask

    task automatic test_second_key();
        int n;
        bit ok;
        k1_r = 2'd0; k1_c = 2'd0; k1_en = 1'b1;
        wait_pressed(1'b1, 200, n, ok);
        repeat (2) @(negedge clk);
        vcnt = 0;
        k2_r = 2'd1; k2_c = 2'd1; k2_en = 1'b1;
        repeat (40) @(negedge clk);
        total_cnt++;
        if (!ok || vcnt != 0 || key_code !== 4'd1 || key_pressed !== 1'b1)
            $display("FAIL second_key: ok=%b valid=%0d code=%0d kp=%b, required 1 0 1 1", ok, vcnt, key_code, key_pressed);
        else pass_cnt++;
        release_all("second_key");
    endtask

    task automatic test_reset_in_pressed();
        int n;
        bit ok;
        k1_r = 2'd1; k1_c = 2'd0; k1_en = 1'b1;
        wait_pressed(1'b1, 200, n, ok);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if ({col_n, key_pressed, key_valid, key_code, is_sign_key, key_neg} !== {4'b1110, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0})
            $display("FAIL async_reset: ok=%b col_n=%b kp=%b kv=%b code=%0d sign=%b neg=%b, required 1110 0 0 0 0 0",
                     ok, col_n, key_pressed, key_valid, key_code, is_sign_key, key_neg);
        else pass_cnt++;
        @(negedge clk);
        vcnt = 0;
        rst = 1'b1;
        wait_pressed(1'b1, 200, n, ok);
        total_cnt++;
        if (!ok || n < 11 || key_code !== 4'd4)
            $display("FAIL reset_redebounce: ok=%b cycles=%0d code=%0d, required 1 >=11 4", ok, n, key_code);
        else pass_cnt++;
        repeat (4) @(negedge clk);
        total_cnt++;
        if (vcnt != 1) $display("FAIL reset_valid_count: valid=%0d, required 1", vcnt);
        else pass_cnt++;
        release_all("reset_pressed");
    endtask

    initial begin
        test_reset();
        test_basic_press();
        test_sign_keys();
        test_bounce();
        test_multi_row();
        test_release_glitch();
        test_second_key();
        test_reset_in_pressed();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
